// File: rtl/multicycle_main_control.sv
// Multicycle MIPS main control FSM.
// Sequences fetch/decode/execute/memory/writeback and drives the datapath
// enables plus the 2-bit ALUOp for the downstream ALU control decoder.
// Memory states wait on mem_ready and abort back to FETCH after MAX_WAIT cycles.
// Optional build macro: MC_JUMP_EN enables the j instruction (JUMP state).
// Without it, opcode 000010 is reported as illegal.
module multicycle_main_control #(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RCOMP  = 4'd7,
    BEQ    = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              wait_hit;

  assign wait_hit = (wait_q == WAIT_LAST);

  // Next-state, wait-counter and control decode from the current state.
  // The counter defaults to zero, so it is cleared on every entry to a
  // memory state and whenever an access completes or times out.
  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;

    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = DECODE;
        end else if (wait_hit) begin
          // Fetch restarts; PC was never written.
          mem_timeout = 1'b1;
          state_d     = FETCH;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_RTYPE:     state_d = EXEC;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BEQ;
          OP_ADDI:      state_d = ADDIEX;
`ifdef MC_JUMP_EN
          OP_J:         state_d = JUMP;
`endif
          default: begin
            illegal_op = 1'b1;
            state_d    = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          state_d = MEMWB;
        end else if (wait_hit) begin
          // Load abandoned: MEMWB is skipped, so no register write.
          mem_timeout = 1'b1;
          state_d     = FETCH;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          state_d = FETCH;
        end else if (wait_hit) begin
          mem_timeout = 1'b1;
          state_d     = FETCH;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = RCOMP;
      end
      RCOMP: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        state_d     = FETCH;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
`ifdef MC_JUMP_EN
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        state_d  = FETCH;
      end
`endif
      // Unreachable codes: all outputs stay 0, recover to FETCH.
      default: state_d = FETCH;
    endcase

    // Reset suppresses every output immediately, so an abandoned
    // instruction cannot complete a write.
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
      illegal_op  = 1'b0;
      mem_timeout = 1'b0;
    end
  end

  // Debug view of the state register, zero while reset is asserted.
  always_comb begin
    state = reset ? 4'd0 : state_q;
  end

  // State register and wait counter with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Multicycle MIPS main control FSM; sits directly upstream of the ALU control decoder.
- Consumes the opcode from the instruction register.
- Sequences fetch/decode/execute/memory/writeback.
- Drives datapath enables and the 2-bit ALUOp (00 add, 01 sub, 10 R-type funct decode) consumed by the ALU control decoder.
- Supports memory wait states via a ready handshake with timeout.

Parameters:
MAX_WAIT, 16, max cycles a memory state waits for mem_ready before abort (1..255)
WAIT_W, 8, width of internal wait counter

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
Op  in  6  opcode, IR[31:26], valid from DECODE onward
mem_ready  in  1  memory completes current access this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU Zero (beq)
IorD  out  1  0 = PC addresses memory, 1 = ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
MemtoReg  out  1  1 = MDR to register write data
IRWrite  out  1  load instruction register
RegDst  out  1  1 = rd, 0 = rt
RegWrite  out  1  register file write
ALUSrcA  out  1  0 = PC, 1 = register A
ALUSrcB  out  2  00 B, 01 const 4, 10 signext imm, 11 signext imm<<2
ALUOp  out  2  to ALU control decoder
PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
illegal_op  out  1  one-cycle pulse on unsupported opcode
mem_timeout  out  1  one-cycle pulse on memory wait timeout
state  out  4  current state, debug

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RCOMP=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11.
  - Codes 12-15 are unreachable; if entered, return to FETCH next cycle with all outputs 0.
- Reset: while reset=1, state<=FETCH, wait counter<=0, and all outputs are forced to 0 combinationally. Reset mid-instruction abandons it with no write.
- Outputs decode from the state register. Exception: the enables gated by mem_ready, listed below.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - mem_ready=1 -> DECODE; otherwise stay.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Op:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BEQ
  - 001000 -> ADDIEX
  - 000010 -> JUMP (see optional feature)
  - any other -> FETCH with illegal_op=1 for this cycle
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: MemRead=1, IorD=1. mem_ready -> MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
- MEMWR: MemWrite=1, IorD=1. mem_ready -> FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RCOMP.
- RCOMP: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
- JUMP: PCWrite=1, PCSource=10 -> FETCH.
- Wait counter:
  - Cleared on entry to FETCH/MEMRD/MEMWR and whenever mem_ready=1.
  - Increments each cycle in those states while mem_ready=0.
  - When the count reaches MAX_WAIT-1 with mem_ready=0: mem_timeout=1 for one cycle, next state FETCH, counter cleared.
  - In MEMRD/MEMWR this aborts the instruction; MEMWB is not entered and no write occurs.
  - In FETCH the fetch restarts; PC unchanged.
- mem_ready=1 in the same cycle as the timeout threshold: completion wins; no mem_timeout.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- CPI by instruction, zero wait states:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
- Each wait cycle adds 1.

Optional Feature:
- MC_JUMP_EN defined: Op 000010 -> JUMP state as above.
- MC_JUMP_EN undefined:
  - JUMP state is not implemented.
  - Op 000010 is treated as illegal: DECODE -> FETCH, illegal_op pulse.
  - PCSource never equals 10.

Test Plan:
- reset=1 for 2 cycles, Op=100011, mem_ready=0 -> all outputs 0, state=0; after release: state=0, MemRead=1, PCWrite=0.
- lw (Op=100011), mem_ready always 1 -> states 0,1,2,3,4,0. ALUOp sequence 00,00,00. RegWrite=1 and MemtoReg=1 only in state 4.
- R-type (Op=000000) -> state 6 shows ALUOp=10, ALUSrcA=1, ALUSrcB=00. State 7 shows RegDst=1, RegWrite=1. Total 4 cycles.
- beq (Op=000100) -> state 8 shows ALUOp=01, PCWriteCond=1, PCSource=01; back to FETCH after 3 cycles.
- sw with MAX_WAIT=4, mem_ready held 0 in MEMWR:
  - MemWrite=1 for 4 cycles, mem_timeout pulse on the 4th, then state=0.
  - Repeat with mem_ready=1 on the 4th cycle -> no timeout.
- Op=111111 -> illegal_op=1 in DECODE, next state 0. Op=000010: JUMP (PCWrite=1, PCSource=10) with MC_JUMP_EN, illegal_op without.
